demux_burst_sched: RTL and testbench
====================================

Name: demux_burst_sched

Overview:
- Sequencer for the 1-to-4 demultiplexer datapath.
- Accepts a single ready/valid input word stream and steers each word to one of four output channels.
- Bursts of BURST_LEN words are locked to one channel. The channel is taken either from an address field or from a round-robin pointer.
- Holds one registered word in flight; sustains 1 word/cycle when the selected channel is ready.

Parameters:
- DATA_W, 8, width of data word.
- BURST_LEN, 4, words per burst before channel re-selection; legal 1..256.
- TIMEOUT_CYC, 16, stall limit in cycles; used only with DEMUX_TIMEOUT_EN; legal 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- mode  in  1  0 = addressed (use in_dest), 1 = round-robin.
- in_dest  in  2  destination channel, sampled only at burst start in addressed mode.
- in_valid  in  1  input word valid.
- in_ready  out  1  input may be accepted this cycle.
- in_data  in  DATA_W  input word.
- out_valid  out  4  one-hot channel valid; bit k = channel k.
- out_ready  in  4  per-channel ready.
- out_data  out  DATA_W  registered word, shared by all channels.
- cur_sel  out  2  channel currently locked/selected.
- busy  out  1  high while a burst is in progress (state != IDLE).
- drop  out  1  one-cycle pulse when a word is discarded by timeout; tied 0 without DEMUX_TIMEOUT_EN.

Behaviour:
- Reset (async, immediate): state=IDLE, out_valid=0, out_data=0, cur_sel=0, rr_ptr=0, beat_cnt=0, busy=0, drop=0, stall counter=0.
- Handshakes:
  - Input accept: in_valid & in_ready.
  - Output transfer: out_valid[cur_sel] & out_ready[cur_sel].
- in_ready = (register empty) | (output transfer this cycle). This combinational path from out_ready is intended.
- Latency: an accepted word appears on out_data/out_valid the next cycle.
- States:
  - IDLE: no burst lock, register empty. in_ready=1. On accept:
    - cur_sel <= (mode ? rr_ptr : in_dest)
    - latch in_data
    - beat_cnt <= 0
    - go to FULL.
  - FULL: register valid; out_valid = one-hot(cur_sel), all other bits 0.
    - No transfer: hold data and valid stable.
    - Transfer, not last beat (beat_cnt < BURST_LEN-1): beat_cnt+1. Simultaneous accept -> stay FULL with the new word. Otherwise -> GAP.
    - Transfer on last beat: beat_cnt <= 0; lock released. In round-robin mode, rr_ptr <= cur_sel+1 mod 4 (3 wraps to 0). Simultaneous accept -> new cur_sel is computed as in IDLE from the updated pointer/in_dest, stay FULL. Otherwise -> IDLE.
  - GAP: mid-burst, register empty, lock held. in_ready=1. On accept: latch data, cur_sel unchanged, go to FULL. in_dest is ignored.
- Addressed mode ignores in_dest mid-burst. A mode change mid-burst takes effect at the next burst start only.
- rr_ptr does not advance in addressed mode.
- BURST_LEN=1: every word is a fresh selection; GAP is never entered.
- out_ready on non-selected channels is ignored.
- Reset asserted mid-burst aborts immediately. The in-flight word is lost and no output pulses.

Optional Feature:
- Macro: DEMUX_TIMEOUT_EN.
- Defined:
  - A stall counter counts cycles in FULL without a transfer; it clears on any transfer or state change.
  - When the count reaches TIMEOUT_CYC-1, the word is discarded: out_valid->0 and drop pulses 1 cycle.
  - The beat counts as delivered, so burst/rr_ptr rules apply as for a transfer.
  - in_ready is not asserted in the drop cycle.
- Undefined: no counter; words are held indefinitely; drop is constant 0.

Test Plan:
- Reset then mode=0, in_dest=2, 4 words 0x11..0x14 back-to-back, out_ready=4'b1111 -> out_valid=4'b0100 for 4 consecutive cycles starting 1 cycle after first accept, data 0x11..0x14; busy falls after the 4th.
- mode=1, 12 words continuous, all ready -> bursts on channels 0,1,2 in order, 4 words each, no idle cycles; rr_ptr ends at 3.
- mode=0, burst to ch1, in_dest switched to 3 after word 2 -> words 3-4 still go to ch1; next burst goes to ch3.
- Burst to ch0 with out_ready[0]=0 for 5 cycles on word 2 -> out_data stable, in_ready=0 during stall; out_ready[2]=1 has no effect.
- Assert rst during word 3 of a burst -> all outputs 0 in the same cycle; after release, the next round-robin burst goes to ch0.
- With DEMUX_TIMEOUT_EN and TIMEOUT_CYC=16, out_ready=0 -> drop=1 exactly 16 cycles after out_valid rose; then out_valid=0; the next word goes to the same channel (beat 2).

Source files
------------

// File: rtl/demux_burst_sched.sv
// Burst-locked 1-to-4 demultiplexer sequencer with a single registered word in flight.
// Optional stall timeout with word discard enabled by defining DEMUX_TIMEOUT_EN.
module demux_burst_sched #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [1:0]        in_dest,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        cur_sel,
  output logic              busy,
  output logic              drop
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  if (BURST_LEN < 1 || BURST_LEN > 256 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("demux_burst_sched: parameter out of legal range");
  end

  typedef enum logic [1:0] {S_IDLE, S_FULL, S_GAP} state_t;

  state_t              r_state, w_nxt_state;
  logic [DATA_W-1:0]   r_data, w_nxt_data;
  logic [1:0]          r_sel, w_nxt_sel;
  logic [1:0]          r_rr, w_nxt_rr;
  logic                r_rr_mode, w_nxt_rr_mode;
  logic [CNT_W-1:0]    r_beat, w_nxt_beat;

  logic w_xfer, w_done, w_last, w_accept, w_timeout, w_hold_off;

`ifdef DEMUX_TIMEOUT_EN
  logic [15:0] r_stall;
  logic        r_drop;

  assign w_timeout  = (r_state == S_FULL) && !w_xfer && (r_stall == 16'(TIMEOUT_CYC - 1));
  assign w_hold_off = r_drop;
  assign drop       = r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_timeout;
      if ((r_state == S_FULL) && !w_xfer && !w_timeout)
        r_stall <= r_stall + 16'd1;
      else
        r_stall <= '0;
    end
  end
`else
  assign w_timeout  = 1'b0;
  assign w_hold_off = 1'b0;
  assign drop       = 1'b0;
`endif

  assign w_xfer    = (r_state == S_FULL) && out_ready[r_sel];
  // A timed-out word counts as a delivered beat for burst accounting.
  assign w_done    = w_xfer || w_timeout;
  assign w_last    = (r_beat == CNT_W'(BURST_LEN - 1));
  assign in_ready  = !w_hold_off && ((r_state != S_FULL) || w_xfer);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = (r_state == S_FULL) ? (4'b0001 << r_sel) : 4'b0000;
  assign out_data  = r_data;
  assign cur_sel   = r_sel;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_data    = r_data;
    w_nxt_sel     = r_sel;
    w_nxt_rr      = r_rr;
    w_nxt_rr_mode = r_rr_mode;
    w_nxt_beat    = r_beat;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt_state   = S_FULL;
          w_nxt_sel     = mode ? r_rr : in_dest;
          w_nxt_rr_mode = mode;
          w_nxt_beat    = '0;
          w_nxt_data    = in_data;
        end
      end
      S_FULL: begin
        if (w_done) begin
          if (!w_last) begin
            w_nxt_beat = r_beat + CNT_W'(1);
            if (w_accept) begin
              w_nxt_data = in_data;
            end else begin
              w_nxt_state = S_GAP;
            end
          end else begin
            w_nxt_beat = '0;
            if (r_rr_mode) w_nxt_rr = r_sel + 2'd1;
            // Back-to-back burst start selects from the already-advanced pointer.
            if (w_accept) begin
              w_nxt_sel     = mode ? w_nxt_rr : in_dest;
              w_nxt_rr_mode = mode;
              w_nxt_data    = in_data;
            end else begin
              w_nxt_state = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        if (w_accept) begin
          w_nxt_state = S_FULL;
          w_nxt_data  = in_data;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_sel     <= '0;
      r_rr      <= '0;
      r_rr_mode <= 1'b0;
      r_beat    <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_data    <= w_nxt_data;
      r_sel     <= w_nxt_sel;
      r_rr      <= w_nxt_rr;
      r_rr_mode <= w_nxt_rr_mode;
      r_beat    <= w_nxt_beat;
    end
  end

endmodule

// File: tb/tb_demux_burst_sched.sv
// Self-checking bench for demux_burst_sched: directed scenarios plus randomized traffic
// compared each cycle against a transaction-level burst model.
module tb_demux_burst_sched;
  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [1:0]    in_dest;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    cur_sel;
  logic          busy;
  logic          drop;

  always #5 clk = ~clk;

  demux_burst_sched #(.DATA_W(DW), .BURST_LEN(BL), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_dest(in_dest),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cur_sel(cur_sel), .busy(busy), .drop(drop)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Model: words waiting for delivery, plus the open burst's channel and delivered-beat count.
  logic [DW-1:0] m_held[$];
  bit            m_open;
  int unsigned   m_beats;
  logic [1:0]    m_ch;
  logic [1:0]    m_rr;
  bit            m_burst_rr;

  task automatic model_reset();
    m_held.delete();
    m_open     = 0;
    m_beats    = 0;
    m_ch       = 2'd0;
    m_rr       = 2'd0;
    m_burst_rr = 0;
  endtask

  task automatic reset_checks();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cur_sel", cur_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // Called just after a rising edge; asserts reset mid-cycle and releases it on the falling edge.
  task automatic async_reset();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 reset_checks();
    @(negedge clk) rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [1:0] dst,
                     input logic m, input logic [3:0] rdy);
    logic [3:0] ev;
    logic       er;
    bit         deliver;
    bit         accept;
    in_valid  = v;
    in_data   = d;
    in_dest   = dst;
    mode      = m;
    out_ready = rdy;
    @(negedge clk);
    ev = (m_held.size() != 0) ? (4'b0001 << m_ch) : 4'b0000;
    er = (m_held.size() == 0) || rdy[m_ch];
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, er);
    chk("busy", busy, m_open);
    chk("drop", drop, 0);
    if (m_held.size() != 0) chk("out_data", out_data, m_held[0]);
    if (m_open) chk("cur_sel", cur_sel, m_ch);
    @(posedge clk);
    deliver = (m_held.size() != 0) && rdy[m_ch];
    accept  = v && er;
    if (deliver) begin
      void'(m_held.pop_front());
      m_beats++;
      if (m_beats == BL) begin
        if (m_burst_rr) m_rr = m_ch + 2'd1;
        m_beats = 0;
        m_open  = 0;
      end
    end
    if (accept) begin
      if (!m_open) begin
        m_open     = 1;
        m_ch       = m ? m_rr : dst;
        m_burst_rr = m;
      end
      m_held.push_back(d);
    end
    #1;
  endtask

  initial begin
    logic [3:0] rdy;
    rst = 1'b1; mode = 1'b0; in_dest = 2'd0; in_valid = 1'b0;
    in_data = '0; out_ready = 4'h0;
    model_reset();
    #3 reset_checks();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Addressed burst to channel 2, back-to-back.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h11 + i), 2'd2, 1'b0, 4'hF);
    repeat (2) cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Round-robin: three full bursts on 0,1,2, then one on 3.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 2'd0, 1'b1, 4'hF);
    repeat (2) cyc(1'b0, 8'h00, 2'd0, 1'b1, 4'hF);

    // in_dest changes mid-burst must not move the lock.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), (i < 2) ? 2'd1 : 2'd3, 1'b0, 4'hF);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 2'd3, 1'b0, 4'hF);
    repeat (2) cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Stall on channel 0 while only a non-selected channel is ready.
    cyc(1'b1, 8'hA1, 2'd0, 1'b0, 4'hF);
    cyc(1'b1, 8'hA2, 2'd0, 1'b0, 4'hF);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 2'd0, 1'b0, 4'b0100);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 2'd0, 1'b0, 4'hF);
    repeat (2) cyc(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Reset in the middle of a round-robin burst, then restart from channel 0.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 2'd0, 1'b1, 4'hF);
    async_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'($urandom), 2'd2, 1'b1, 4'hF);

    for (int i = 0; i < 800; i++) begin
      rdy = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 9) == 0) rdy = 4'h0;
      if ($urandom_range(0, 199) == 0) async_reset();
      cyc($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), 1'($urandom), rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
